rps_match_ctrl: RTL
===================

# rps_match_ctrl

Match controller for the Rock-Paper-Scissors datapath. It collects one move per player per round through lock strobes and validates each move's one-hot encoding on acceptance. It judges each round, keeps both scores and the round count, and ends the match when a player reaches `WIN_ROUNDS` round wins. It sits between the player input debouncers and the score/display logic.

## Interface
- `WIN_ROUNDS`, default 3: round wins needed to take the match; legal range 1..2^SCORE_W-1.
- `SCORE_W`, default 3: width of each score counter; must hold `WIN_ROUNDS`.
- `TIMEOUT_CYC`, default 1000: collect-phase timeout in cycles; used only with `RPS_TIMEOUT_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a match from IDLE or OVER.
- `lockA` / `lockB`  in  1  one-cycle strobe that submits the player's current move.
- `inA` / `inB`  in  3  move; one-hot, 001 rock, 010 paper, 100 scissors.
- `errA` / `errB`  out  1  one-cycle pulse: a lock was rejected because its encoding was invalid.
- `round_done`  out  1  one-cycle pulse: the round was judged.
- `round_result`  out  2  00 draw, 01 A wins, 10 B wins; held until the next `round_done`.
- `scoreA` / `scoreB`  out  SCORE_W  round wins per player.
- `round_cnt`  out  8  rounds judged in the current match; saturates at 255.
- `match_done`  out  1  high while in OVER.
- `match_winner`  out  2  01 A, 10 B, 00 none.
- `busy`  out  1  high in COLLECT or JUDGE.

## Operation
- States are IDLE, COLLECT, JUDGE and OVER. Reset enters IDLE. Every output resets to 0, as do both lock flags, both stored moves and the timeout counter.
- IDLE + `start` → COLLECT. This clears the scores, `round_cnt`, `round_result` and `match_winner`.
- COLLECT, per player:
  - A `lock` with a valid move, while that player's flag is clear, stores the move and sets the flag.
  - A `lock` with an invalid move (000, 011, 101, 110 or 111) is rejected. It pulses `err` and leaves the flag clear.
  - A `lock` while the player's flag is already set is ignored; the first move stands and no `err` pulse is raised.
- COLLECT → JUDGE once both flags are set. Locks arriving on the same edge are both processed.
- `lock` and `start` are ignored in JUDGE. `lock` is ignored in IDLE and OVER. `start` is ignored in COLLECT and JUDGE.
- JUDGE always lasts one cycle. On its exiting edge:
  - `round_result` is set from the stored moves. Equal moves give a draw. Rock beats scissors, scissors beat paper, paper beats rock.
  - The winner's score is incremented; a draw leaves both scores unchanged.
  - `round_cnt` is incremented, saturating at 255.
  - `round_done` pulses.
  - Both flags are cleared.
  - The next state is OVER if the incremented score equals `WIN_ROUNDS`, else COLLECT.
- OVER:
  - `match_done` = 1 and `match_winner` = the player who reached `WIN_ROUNDS`.
  - `start` → COLLECT with a full clear.
- `rst` asserted in any state, including mid-round, returns the block to its reset state on that edge.

## Timing
- Inputs are sampled on the rising edge. All outputs are registered.
- If the second valid lock is sampled at edge t: JUDGE is held during cycle t+1. `round_done`, the new scores and the new `round_result` are visible from edge t+2, as is the next state (COLLECT or OVER).
- An `err` pulse appears for the cycle after the rejected lock edge.
- A new round can accept locks from the first COLLECT cycle after `round_done`.

## Configuration
- `RPS_TIMEOUT_EN` defined:
  - A counter runs in COLLECT and restarts at every COLLECT entry.
  - If the round is not complete after `TIMEOUT_CYC` cycles, the block forces JUDGE.
  - If exactly one player locked, that player wins the round.
  - If neither player locked, the round is a draw.
  - If both flags become set on the timeout edge, the lock wins and the round is judged normally.
- `RPS_TIMEOUT_EN` undefined: COLLECT waits indefinitely and no timeout logic is built.

## Structure
- Package `rps_pkg`:
  - Move constants ROCK, PAPER, SCISSORS.
  - Result encodings DRAW, A_WIN, B_WIN.
  - State enum.
  - Function `beats(m1, m2)`.
- Sub-module `rps_move_check`: single-move one-hot validator (3-bit in, 1-bit valid out), instantiated once per player.

## Test plan
- Start, A locks 001 (rock), B locks 100 (scissors) on the same edge → `round_done` 2 edges later, `round_result`=01, `scoreA`=1, `round_cnt`=1.
- A locks 011 → `errA` pulse for one cycle, flag stays clear. A then locks 010 (paper) and B locks 010 → draw, scores unchanged, `round_cnt`=1.
- A locks 001, then locks 010 before B locks 010 → rock is kept; B wins, `scoreB`=1.
- B wins 3 rounds with `WIN_ROUNDS`=3 → OVER, `match_done`=1, `match_winner`=10. Locks are then ignored; `start` clears all counters.
- `rst` asserted while in JUDGE → next cycle IDLE with every output 0.
- With `RPS_TIMEOUT_EN` and `TIMEOUT_CYC`=16, only A locks → A wins the round after the timeout. With no locks at all → draw.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors match controller.
// Move and result encodings, FSM state enum and the beats() rule.
package rps_pkg;

  localparam logic [2:0] ROCK     = 3'b001;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b100;

  localparam logic [1:0] DRAW  = 2'b00;
  localparam logic [1:0] A_WIN = 2'b01;
  localparam logic [1:0] B_WIN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_JUDGE,
    S_OVER
  } state_t;

  // True when m1 defeats m2; both must be valid one-hot moves.
  function automatic logic beats(
    input logic [2:0] m1,
    input logic [2:0] m2
  );
    return (m1 == ROCK     && m2 == SCISSORS) ||
           (m1 == SCISSORS && m2 == PAPER)    ||
           (m1 == PAPER    && m2 == ROCK);
  endfunction

endpackage

// File: rtl/rps_move_check.sv
// One-hot move validator: only rock, paper or scissors are legal.
// Purely combinational, one instance per player.
module rps_move_check
  import rps_pkg::*;
(
  input  logic [2:0] move_i,
  output logic       valid_o
);

  assign valid_o = (move_i == ROCK) ||
                   (move_i == PAPER) ||
                   (move_i == SCISSORS);

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: collects locks, judges rounds,
// keeps score. Optional collect timeout built when RPS_TIMEOUT_EN is defined.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int WIN_ROUNDS  = 3,
  parameter int SCORE_W     = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               lockA,
  input  logic               lockB,
  input  logic [2:0]         inA,
  input  logic [2:0]         inB,
  output logic               errA,
  output logic               errB,
  output logic               round_done,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] scoreA,
  output logic [SCORE_W-1:0] scoreB,
  output logic [7:0]         round_cnt,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] WIN_N = SCORE_W'(WIN_ROUNDS);

  state_t             state_q;
  logic               flgA_q, flgB_q;
  logic [2:0]         mvA_q, mvB_q;
  logic               errA_q, errB_q;
  logic               done_q;
  logic [1:0]         res_q;
  logic [SCORE_W-1:0] scA_q, scB_q;
  logic [7:0]         rcnt_q;
  logic               mdone_q;
  logic [1:0]         mwin_q;
  logic               busy_q;

  logic               vA, vB;
  logic               accA, accB;
  logic               rejA, rejB;
  logic [1:0]         res_d;
  logic [SCORE_W-1:0] scA_d, scB_d;
  logic               win_d;
  logic [7:0]         rcnt_d;

  rps_move_check u_chk_a (.move_i(inA), .valid_o(vA));
  rps_move_check u_chk_b (.move_i(inB), .valid_o(vB));

  assign accA = lockA && !flgA_q && vA;
  assign accB = lockB && !flgB_q && vB;
  assign rejA = lockA && !flgA_q && !vA;
  assign rejB = lockB && !flgB_q && !vB;

`ifdef RPS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  // Round verdict from the stored moves; a lone lock wins after timeout.
  always_comb begin
    res_d = DRAW;
    if (flgA_q && flgB_q) begin
      if (beats(mvA_q, mvB_q))
        res_d = A_WIN;
      else if (beats(mvB_q, mvA_q))
        res_d = B_WIN;
    end
`ifdef RPS_TIMEOUT_EN
    else if (flgA_q)
      res_d = A_WIN;
    else if (flgB_q)
      res_d = B_WIN;
`endif
    scA_d  = scA_q + SCORE_W'(res_d == A_WIN);
    scB_d  = scB_q + SCORE_W'(res_d == B_WIN);
    win_d  = (res_d == A_WIN && scA_d == WIN_N) ||
             (res_d == B_WIN && scB_d == WIN_N);
    rcnt_d = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
  end

  // Match FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      flgA_q  <= 1'b0;
      flgB_q  <= 1'b0;
      mvA_q   <= '0;
      mvB_q   <= '0;
      errA_q  <= 1'b0;
      errB_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= DRAW;
      scA_q   <= '0;
      scB_q   <= '0;
      rcnt_q  <= '0;
      mdone_q <= 1'b0;
      mwin_q  <= 2'b00;
      busy_q  <= 1'b0;
`ifdef RPS_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      errA_q <= 1'b0;
      errB_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q <= S_COLLECT;
            flgA_q  <= 1'b0;
            flgB_q  <= 1'b0;
            res_q   <= DRAW;
            scA_q   <= '0;
            scB_q   <= '0;
            rcnt_q  <= '0;
            mdone_q <= 1'b0;
            mwin_q  <= 2'b00;
            busy_q  <= 1'b1;
`ifdef RPS_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (accA) begin
            mvA_q  <= inA;
            flgA_q <= 1'b1;
          end
          if (accB) begin
            mvB_q  <= inB;
            flgB_q <= 1'b1;
          end
          errA_q <= rejA;
          errB_q <= rejB;
          if (flgA_q && flgB_q)
            state_q <= S_JUDGE;
`ifdef RPS_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST)
            state_q <= S_JUDGE;
          else
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
        end
        S_JUDGE: begin
          res_q  <= res_d;
          scA_q  <= scA_d;
          scB_q  <= scB_d;
          rcnt_q <= rcnt_d;
          done_q <= 1'b1;
          flgA_q <= 1'b0;
          flgB_q <= 1'b0;
`ifdef RPS_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          if (win_d) begin
            state_q <= S_OVER;
            mdone_q <= 1'b1;
            mwin_q  <= res_d;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_COLLECT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign errA         = errA_q;
  assign errB         = errB_q;
  assign round_done   = done_q;
  assign round_result = res_q;
  assign scoreA       = scA_q;
  assign scoreB       = scB_q;
  assign round_cnt    = rcnt_q;
  assign match_done   = mdone_q;
  assign match_winner = mwin_q;
  assign busy         = busy_q;

endmodule
